// File: rtl/mascota_pkg.sv
// Shared mood codes, default timing and the level-to-mood helpers for the pet controller.
package mascota_pkg;

    typedef enum logic [2:0] {
        FELIZ      = 3'd0,
        NEUTRO     = 3'd1,
        TRISTE     = 3'd2,
        CANSADO    = 3'd3,
        HAMBRIENTO = 3'd4,
        ENFERMO    = 3'd5,
        MUERTO     = 3'd6
    } estado_t;

    localparam int unsigned T_MIN_DEF    = 50_000_000;
    localparam int unsigned T_MUERTE_DEF = 500_000_000;
    localparam int unsigned T_TEST_DEF   = 250_000_000;

    // Most urgent need first; FELIZ only when every level is comfortable.
    function automatic estado_t estado_candidato(input logic [1:0] animo,
                                                 input logic [1:0] energia,
                                                 input logic [1:0] descanso,
                                                 input logic [1:0] medicina);
        estado_t r;
        if (medicina == 2'd0)      r = ENFERMO;
        else if (energia == 2'd0)  r = HAMBRIENTO;
        else if (descanso == 2'd0) r = CANSADO;
        else if (animo == 2'd0)    r = TRISTE;
        else if (animo >= 2'd2 && energia >= 2'd2 && descanso >= 2'd2 && medicina >= 2'd2)
                                   r = FELIZ;
        else                       r = NEUTRO;
        return r;
    endfunction

    function automatic logic [2:0] contar_ceros(input logic [1:0] animo,
                                                input logic [1:0] energia,
                                                input logic [1:0] descanso,
                                                input logic [1:0] medicina);
        return {2'b00, animo == 2'd0} + {2'b00, energia == 2'd0}
             + {2'b00, descanso == 2'd0} + {2'b00, medicina == 2'd0};
    endfunction

endpackage

// File: rtl/controlador_mascota_if.sv
// Need levels and test button in, displayed mood and counter enables out.
interface controlador_mascota_if;

    logic [1:0] Nivel_Animo;
    logic [1:0] Nivel_Energia;
    logic [1:0] Nivel_Descanso;
    logic [1:0] Nivel_Medicina;
    logic       B_Test;
    logic [2:0] Estado;
    logic       Cambio_Estado;
    logic       Modo_Test;
    logic       Activo_Comida;
    logic       Activo_Medicina;

    modport slave (
        input  Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina, B_Test,
        output Estado, Cambio_Estado, Modo_Test, Activo_Comida, Activo_Medicina
    );

    modport master (
        output Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina, B_Test,
        input  Estado, Cambio_Estado, Modo_Test, Activo_Comida, Activo_Medicina
    );

endinterface

// File: rtl/temporizador_sat.sv
// Saturating up-counter; lleno flags count == LIMITE. clr wins over en.
module temporizador_sat #(
    parameter int unsigned LIMITE = 4
) (
    input  logic clk,
    input  logic B_reset,
    input  logic clr,
    input  logic en,
    output logic lleno
);

    localparam int unsigned W = (LIMITE < 1) ? 1 : $clog2(LIMITE + 1);
    localparam logic [W-1:0] TOPE = W'(LIMITE);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (B_reset || clr)
            cnt <= '0;
        else if (en && cnt != TOPE)
            cnt <= cnt + 1'b1;
    end

    assign lleno = (cnt == TOPE);

endmodule

// File: rtl/controlador_mascota.sv
// Pet mood FSM with dwell/death timers and a test overlay cycling all mood codes.
module controlador_mascota
    import mascota_pkg::*;
#(
    parameter int unsigned T_MIN    = T_MIN_DEF,
    parameter int unsigned T_MUERTE = T_MUERTE_DEF,
    parameter int unsigned T_TEST   = T_TEST_DEF
) (
    input  logic                  clk,
    input  logic                  B_reset,
    controlador_mascota_if.slave  bus
);

    estado_t    est_q, est_d, cand;
    logic       modo_q, modo_d;
    logic [2:0] test_q, test_d, estado_d;
    logic       dwell_lleno, muerte_lleno, test_lleno;
    logic       muerto, cargar, varios_ceros;

    assign cand = estado_candidato(bus.Nivel_Animo, bus.Nivel_Energia,
                                   bus.Nivel_Descanso, bus.Nivel_Medicina);
    assign varios_ceros = contar_ceros(bus.Nivel_Animo, bus.Nivel_Energia,
                                       bus.Nivel_Descanso, bus.Nivel_Medicina) >= 3'd2;
    assign muerto = (est_q == MUERTO);
    assign cargar = !muerto && (cand != est_q) && dwell_lleno;

    temporizador_sat #(.LIMITE(T_MIN)) u_dwell (
        .clk(clk), .B_reset(B_reset), .clr(cargar), .en(!muerto), .lleno(dwell_lleno)
    );

    temporizador_sat #(.LIMITE(T_MUERTE)) u_muerte (
        .clk(clk), .B_reset(B_reset), .clr(!muerto && !varios_ceros),
        .en(!muerto && varios_ceros), .lleno(muerte_lleno)
    );

    // Counting starts the cycle after a pulse and the exit is registered, so the
    // limit sits two short of T_TEST to drop Modo_Test exactly T_TEST cycles later.
    temporizador_sat #(.LIMITE(T_TEST - 2)) u_test (
        .clk(clk), .B_reset(B_reset), .clr(bus.B_Test || !modo_q), .en(modo_q),
        .lleno(test_lleno)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        est_d  = est_q;
        modo_d = modo_q;
        test_d = test_q;
        if (!muerto) begin
            if (muerte_lleno) est_d = MUERTO;
            else if (cargar)  est_d = cand;
        end
        if (bus.B_Test) begin
            if (!modo_q) begin
                modo_d = 1'b1;
                test_d = 3'd0;
            end else begin
                test_d = (test_q == 3'd6) ? 3'd0 : test_q + 3'd1;
            end
        end else if (modo_q && test_lleno) begin
            modo_d = 1'b0;
        end
        estado_d = modo_d ? test_d : est_d;
    end

    always_ff @(posedge clk) begin
        if (B_reset) begin
            est_q               <= FELIZ;
            modo_q              <= 1'b0;
            test_q              <= 3'd0;
            bus.Estado          <= 3'd0;
            bus.Cambio_Estado   <= 1'b0;
            bus.Modo_Test       <= 1'b0;
            bus.Activo_Comida   <= 1'b0;
            bus.Activo_Medicina <= 1'b0;
        end else begin
            est_q               <= est_d;
            modo_q              <= modo_d;
            test_q              <= test_d;
            bus.Estado          <= estado_d;
            bus.Cambio_Estado   <= (estado_d != bus.Estado);
            bus.Modo_Test       <= modo_d;
            bus.Activo_Comida   <= !modo_d && est_d != MUERTO && est_d != CANSADO
                                   && bus.Nivel_Energia != 2'd3;
            bus.Activo_Medicina <= !modo_d && est_d != MUERTO && bus.Nivel_Medicina != 2'd3;
        end
    end

endmodule

// File: tb/tb_controlador_mascota.sv
// Directed bench for controlador_mascota with shortened timers (T_MIN=4, T_MUERTE=8, T_TEST=6).
module tb_controlador_mascota;

    localparam int unsigned TM = 4;
    localparam int unsigned TD = 8;
    localparam int unsigned TT = 6;

    logic clk = 1'b0;
    logic B_reset;

    controlador_mascota_if bus ();

    controlador_mascota #(.T_MIN(TM), .T_MUERTE(TD), .T_TEST(TT)) dut (
        .clk(clk), .B_reset(B_reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] a, e, d, m;
        logic       tst;
        logic [2:0] est;
        logic       cam, mod, com, med;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] a, input logic [1:0] e,
                                input logic [1:0] d, input logic [1:0] m, input logic tst,
                                input logic [2:0] est, input logic cam, input logic mod,
                                input logic com, input logic med);
        vec_t v;
        v.rst = rst; v.a = a; v.e = e; v.d = d; v.m = m; v.tst = tst;
        v.est = est; v.cam = cam; v.mod = mod; v.com = com; v.med = med;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        B_reset            = v.rst;
        bus.Nivel_Animo    = v.a;
        bus.Nivel_Energia  = v.e;
        bus.Nivel_Descanso = v.d;
        bus.Nivel_Medicina = v.m;
        bus.B_Test         = v.tst;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, " Estado"},          {5'd0, bus.Estado},      {5'd0, v.est});
        check({tag, " Cambio_Estado"},   {7'd0, bus.Cambio_Estado},   {7'd0, v.cam});
        check({tag, " Modo_Test"},       {7'd0, bus.Modo_Test},       {7'd0, v.mod});
        check({tag, " Activo_Comida"},   {7'd0, bus.Activo_Comida},   {7'd0, v.com});
        check({tag, " Activo_Medicina"}, {7'd0, bus.Activo_Medicina}, {7'd0, v.med});
    endtask

    task automatic step(input string tag, input vec_t v);
        apply(v);
        compare(tag, v);
    endtask

    initial begin
        B_reset            = 1'b1;
        bus.Nivel_Animo    = 2'd3;
        bus.Nivel_Energia  = 2'd3;
        bus.Nivel_Descanso = 2'd3;
        bus.Nivel_Medicina = 2'd3;
        bus.B_Test         = 1'b0;

        //                rst  A  E  D  M tst  est cam mod com med
        tbl.push_back(mk(1, 3, 3, 3, 3, 0,   0,  0,  0,  0,  0));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(0, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0));
        // Hunger past the dwell window, then back to happy after a full dwell.
        tbl.push_back(mk(0, 3, 0, 3, 3, 0,   4,  1,  0,  1,  0));
        tbl.push_back(mk(0, 3, 0, 3, 3, 0,   4,  0,  0,  1,  0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 3, 2, 3, 3, 0, 4, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   0,  1,  0,  1,  0));
        // Test overlay: three pulses, NEUTRO loads underneath, exit 6 cycles later.
        tbl.push_back(mk(0, 3, 2, 3, 1, 0,   0,  0,  0,  1,  1));
        tbl.push_back(mk(0, 3, 2, 3, 1, 1,   0,  0,  1,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 1, 0,   0,  0,  1,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 1, 1,   1,  1,  1,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 1, 0,   1,  0,  1,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 1, 1,   2,  1,  1,  0,  0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 3, 2, 3, 1, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3, 2, 3, 1, 0,   1,  1,  0,  1,  1));
        tbl.push_back(mk(0, 3, 2, 3, 1, 0,   1,  0,  0,  1,  1));
        // Descanso toggling every 2 cycles: at most one change per dwell window.
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   3,  1,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   3,  0,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   3,  0,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   3,  0,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   3,  0,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   3,  0,  0,  0,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   0,  1,  0,  1,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   0,  0,  0,  1,  0));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   0,  0,  0,  1,  0));
        tbl.push_back(mk(0, 3, 2, 0, 3, 0,   0,  0,  0,  1,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   0,  0,  0,  1,  0));
        tbl.push_back(mk(0, 3, 2, 3, 3, 0,   0,  0,  0,  1,  0));

        foreach (tbl[i])
            step($sformatf("row%0d", i), tbl[i]);

        // Two zero levels: ENFERMO first, MUERTO 8 cycles later.
        step("death_entry", mk(0, 3, 0, 3, 0, 0, 5, 1, 0, 1, 1));
        for (int i = 0; i < 7; i++)
            step($sformatf("death_wait%0d", i), mk(0, 3, 0, 3, 0, 0, 5, 0, 0, 1, 1));
        step("death", mk(0, 3, 0, 3, 0, 0, 6, 1, 0, 0, 0));

        // Restored levels cannot revive the pet.
        for (int i = 0; i < 3; i++)
            step($sformatf("dead_hold%0d", i), mk(0, 3, 3, 3, 3, 0, 6, 0, 0, 0, 0));

        // Overlay on top of MUERTO, then reset dominates a simultaneous pulse.
        step("test_dead0",    mk(0, 3, 3, 3, 3, 1, 0, 1, 1, 0, 0));
        step("test_dead1",    mk(0, 3, 3, 3, 3, 0, 0, 0, 1, 0, 0));
        step("test_dead2",    mk(0, 3, 3, 3, 3, 1, 1, 1, 1, 0, 0));
        step("reset_in_test", mk(1, 3, 3, 3, 3, 1, 0, 0, 0, 0, 0));
        step("after_reset",   mk(0, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_mascota.md
# controlador_mascota

Central behaviour controller for the virtual pet. It consumes the four 2-bit need levels produced by the mode counters (Animo, Energia, Descanso, Medicina) and runs the pet state machine that sets the displayed mood. It drives the `Activo_Comida` and `Activo_Medicina` enables back into the Energia and Medicina mode counters. It also owns the test-mode overlay that steps through every mood code for display checkout.

## Interface
Parameters:
- `T_MIN`, 50000000: minimum dwell cycles between normal mood changes (1 s @ 50 MHz).
- `T_MUERTE`, 500000000: cycles with two or more zero levels before death (10 s).
- `T_TEST`, 250000000: idle cycles without a `B_Test` pulse before test mode exits (5 s).

Ports:
- `clk` in 1: system clock; the only clock.
- `B_reset` in 1: reset, synchronous, active-high.
- `Nivel_Animo` in 2: need level, 0 to 3.
- `Nivel_Energia` in 2: need level, 0 to 3.
- `Nivel_Descanso` in 2: need level, 0 to 3.
- `Nivel_Medicina` in 2: need level, 0 to 3.
- `B_Test` in 1: debounced single-cycle pulse.
- `Estado` out 3: displayed mood code.
- `Cambio_Estado` out 1: one-cycle pulse on any change of `Estado`.
- `Modo_Test` out 1: high while the test overlay is active.
- `Activo_Comida` out 1: feeding enable.
- `Activo_Medicina` out 1: medicine enable.

## Operation
- Mood codes:
  - 0 FELIZ, 1 NEUTRO, 2 TRISTE, 3 CANSADO, 4 HAMBRIENTO, 5 ENFERMO, 6 MUERTO.
  - Code 7 is never driven.
- Candidate mood, first match wins:
  - Medicina==0 → ENFERMO.
  - Energia==0 → HAMBRIENTO.
  - Descanso==0 → CANSADO.
  - Animo==0 → TRISTE.
  - All levels ≥2 → FELIZ.
  - Otherwise → NEUTRO.
- Internal state `est` (normal FSM) loads the candidate only when the candidate differs from `est` and the dwell counter has reached `T_MIN`. Loading clears the dwell counter. The dwell counter saturates at `T_MIN`.
- Death counter:
  - Increments while the count of zero levels is ≥2; clears otherwise.
  - On reaching `T_MUERTE`, `est` ← MUERTO immediately, bypassing dwell.
- MUERTO is absorbing: only `B_reset` leaves it. Dwell and death counters freeze in MUERTO.
- Test overlay:
  - A `B_Test` pulse while `Modo_Test`=0 sets `Modo_Test`=1 and test code=0.
  - Each further pulse advances the test code 0→1→…→6→0 and clears the test timeout counter.
  - After `T_TEST` cycles without a pulse, `Modo_Test`=0.
  - `est`, dwell and death logic keep running unchanged underneath the overlay.
- `Estado` = test code if `Modo_Test`, else `est`.
- `Activo_Comida` = 1 iff not `Modo_Test`, `est`∉{MUERTO, CANSADO}, and Nivel_Energia≠3.
- `Activo_Medicina` = 1 iff not `Modo_Test`, `est`≠MUERTO, and Nivel_Medicina≠3.

## Timing
- All outputs are registered. Level inputs affect outputs one cycle after sampling.
- Reset values:
  - `Estado`=0 (FELIZ), `est`=FELIZ.
  - `Cambio_Estado`=0, `Modo_Test`=0, `Activo_Comida`=0, `Activo_Medicina`=0.
  - All counters 0, so the first mood change is possible no earlier than `T_MIN` cycles after reset release.
- Transition timing:
  - A mood change is visible on `Estado` the cycle after the load condition holds.
  - `Cambio_Estado` is asserted in that same cycle.
  - A `B_Test` pulse in cycle n changes `Estado`/`Modo_Test` in cycle n+1.
  - Test timeout: `Modo_Test` falls exactly `T_TEST` cycles after the last pulse.
- Simultaneous events:
  - `B_reset` dominates everything.
  - Death reached while in test: `est`=MUERTO, shown on overlay exit.
  - Test exit and a mood change in the same cycle: `Estado` takes the new `est`, with a single `Cambio_Estado` pulse.
  - Exit to an `est` equal to the last test code produces no pulse.
- Counter widths: `$clog2(param+1)`; no wrap (saturate or clear only).

## Structure
- Shared package `mascota_pkg`:
  - mood code localparams (`FELIZ`…`MUERTO`, 3-bit);
  - default values for `T_MIN`/`T_MUERTE`/`T_TEST`.
- Sub-module `temporizador_sat`:
  - saturating up-counter with parameter `LIMITE` and inputs `clk`, `B_reset`, `clr`, `en`;
  - output `lleno` when count==`LIMITE`;
  - instantiated three times (dwell, death, test timeout).

## Test plan
Run the bench with `T_MIN`=4, `T_MUERTE`=8, `T_TEST`=6.
- All levels 3 after reset → `Estado`=0; `Activo_Comida`=0 and `Activo_Medicina`=0; `Cambio_Estado` never pulses.
- Nivel_Energia=0 at cycle 10 (past dwell) → `Estado`=4 at cycle 11 with one `Cambio_Estado` pulse; `Activo_Comida`=1.
- Medicina=0 and Energia=0 held → `Estado`=5, then 6 after 8 cycles. Restoring levels to 3 keeps `Estado`=6, with both enables 0 until `B_reset`.
- Descanso 0→3→0 toggled every 2 cycles → `est` changes at most once per 4 cycles; `Activo_Comida`=0 while CANSADO.
- Three `B_Test` pulses 2 cycles apart → `Estado` 0,1,2 and `Modo_Test`=1. Enables are 0 throughout. `Modo_Test` falls 6 cycles after the last pulse and `Estado` returns to `est`.
- `B_reset` asserted while in test and MUERTO → next cycle all outputs at reset values.
